// File: rtl/seq101_pkg.sv
// seq101_pkg: shared defaults, controller FSM encodings and detector state encodings
package seq101_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 5;
    typedef logic [2:0] ctrl_state_t;
    localparam ctrl_state_t ST_IDLE  = 3'd0;
    localparam ctrl_state_t ST_CLEAR = 3'd1;
    localparam ctrl_state_t ST_SHIFT = 3'd2;
    localparam ctrl_state_t ST_DRAIN = 3'd3;
    localparam ctrl_state_t ST_DONE  = 3'd4;
    typedef logic [1:0] det_state_t;
    localparam det_state_t S0 = 2'b00;
    localparam det_state_t S1 = 2'b01;
    localparam det_state_t S2 = 2'b11;
    localparam det_state_t S3 = 2'b10;
    // S3 keeps the trailing "1" of a match so overlapping matches chain through S1/S2
    function automatic det_state_t det_next(input det_state_t s, input logic x);
        return x ? ((s == S2) ? S3 : S1) : ((s == S0 || s == S2) ? S0 : S2);
    endfunction
endpackage

// File: rtl/seq101_scan_ctrl_if.sv
// seq101_scan_if: word handshake and result bus between producer and scan controller
interface seq101_scan_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) ();
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic             found;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] first_pos;
    modport master (output start, data_in, input busy, done, found, match_cnt, first_pos);
    modport slave  (input start, data_in, output busy, done, found, match_cnt, first_pos);
endinterface

// File: rtl/seq101_det.sv
// seq101_det: Moore "101" detector with overlap and synchronous clear
module seq101_det
    import seq101_pkg::*;
(
    input  logic clk,
    input  logic clr_n,
    input  logic sclr,
    input  logic x,
    output logic z
);
    det_state_t st;
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) st <= S0;
        else        st <= sclr ? S0 : det_next(st, x);
    end
    assign z = (st == S3);
endmodule

// File: rtl/seq101_scan_ctrl.sv
// seq101_scan_ctrl: accepts a word, shifts it MSB-first through seq101_det and tallies matches
module seq101_scan_ctrl
    import seq101_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic          clk,
    input logic          clr_n,
    seq101_scan_if.slave bus
);
    ctrl_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pos;
    logic             fnd;
    logic             x;
    logic             z;
    logic             sclr;
    logic             hit;
    assign x    = (state == ST_SHIFT) & shreg[WIDTH-1];
    assign sclr = (state == ST_CLEAR);
    // z lags the sampled bit by one edge, so it belongs to bit idx-1
    assign hit  = z & (((state == ST_SHIFT) & (idx != '0)) | (state == ST_DRAIN));
    seq101_det u_det (
        .clk  (clk),
        .clr_n(clr_n),
        .sclr (sclr),
        .x    (x),
        .z    (z)
    );
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
            shreg <= '0;
            idx   <= '0;
            cnt   <= '0;
            pos   <= '0;
            fnd   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    shreg <= bus.data_in;
                    state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    idx   <= '0;
                    cnt   <= '0;
                    pos   <= '0;
                    fnd   <= 1'b0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    shreg <= shreg << 1;
                    idx   <= idx + 1'b1;
                    if (idx == CNT_W'(WIDTH - 1)) state <= ST_DRAIN;
                end
                ST_DRAIN: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
            if (hit) begin
                cnt <= cnt + 1'b1;
                if (!fnd) begin
                    fnd <= 1'b1;
                    pos <= idx - 1'b1;
                end
            end
        end
    end
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.found     = fnd;
    assign bus.match_cnt = cnt;
    assign bus.first_pos = pos;
endmodule

// File: tb/tb_seq101_scan_ctrl.sv
// tb_seq101_scan_ctrl: randomized and directed checks against a sliding-window "101" count model
module tb_seq101_scan_ctrl;
    localparam int W  = 16;
    localparam int CW = 5;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int vecs = 0;
    int errs = 0;
    always #5 clk = ~clk;
    seq101_scan_if #(.WIDTH(W), .CNT_W(CW)) bif ();
    seq101_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .clr_n(clr_n), .bus(bif));

    // bits indexed MSB-first: b[i] = w[W-1-i]; a match ends at i when b[i-2..i] == 1,0,1
    function automatic void model(input logic [W-1:0] w, output int c, output int p);
        c = 0;
        p = 0;
        for (int i = 2; i < W; i++)
            if (w[W+1-i] && !w[W-i] && w[W-1-i]) begin
                if (c == 0) p = i;
                c++;
            end
    endfunction

    task automatic wait_done(output int n, output bit ok);
        n  = 1;
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (bif.done) return;
            if (!bif.busy) ok = 1'b0;
            @(posedge clk);
            n++;
        end
        n = -1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        bif.start = 1'b0;
        bif.data_in = '0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({bif.busy, bif.done, bif.found, bif.match_cnt, bif.first_pos} !== '0) begin
            errs++;
            $display("FAIL reset: got busy=%b done=%b found=%b cnt=%0d pos=%0d, want all 0",
                     bif.busy, bif.done, bif.found, bif.match_cnt, bif.first_pos);
        end
        clr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scan_words();
        logic [W-1:0] words[$];
        int n, c, p;
        bit ok;
        words = '{16'h5555, 16'hAAAA, 16'hA000, 16'h0000, 16'hFFFF};
        repeat (24) words.push_back(W'($urandom));
        foreach (words[k]) begin
            @(negedge clk);
            bif.start = 1'b1;
            bif.data_in = words[k];
            @(posedge clk);
            #1 bif.start = 1'b0;
            bif.data_in = W'($urandom);
            wait_done(n, ok);
            model(words[k], c, p);
            vecs++;
            if (n != W + 3 || !ok) begin
                errs++;
                $display("FAIL scan_latency %h: got %0d cycles busy_ok=%b, want %0d busy_ok=1",
                         words[k], n, ok, W + 3);
            end
            vecs++;
            if ({bif.found, bif.match_cnt, bif.first_pos} !== {c != 0, CW'(c), CW'(p)}) begin
                errs++;
                $display("FAIL scan_result %h: got found=%b cnt=%0d pos=%0d, want found=%b cnt=%0d pos=%0d",
                         words[k], bif.found, bif.match_cnt, bif.first_pos, c != 0, c, p);
            end
            @(negedge clk);
            vecs++;
            if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin
                errs++;
                $display("FAIL scan_idle %h: got done=%b busy=%b, want 0 0", words[k], bif.done, bif.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        @(negedge clk);
        bif.start = 1'b1;
        bif.data_in = 16'h5555;
        @(posedge clk);
        #1 bif.data_in = 16'h0000;
        wait_done(n, ok);
        vecs++;
        if (n != W + 3 || !ok || {bif.found, bif.match_cnt, bif.first_pos} !== {1'b1, CW'(7), CW'(3)}) begin
            errs++;
            $display("FAIL b2b_first: got n=%0d ok=%b found=%b cnt=%0d pos=%0d, want n=%0d ok=1 1 7 3",
                     n, ok, bif.found, bif.match_cnt, bif.first_pos, W + 3);
        end
        @(negedge clk);
        vecs++;
        if (bif.busy !== 1'b0 || {bif.found, bif.match_cnt, bif.first_pos} !== {1'b1, CW'(7), CW'(3)}) begin
            errs++;
            $display("FAIL b2b_hold: got busy=%b found=%b cnt=%0d pos=%0d, want 0 1 7 3",
                     bif.busy, bif.found, bif.match_cnt, bif.first_pos);
        end
        @(posedge clk);
        #1 bif.start = 1'b0;
        bif.data_in = 16'hFFFF;
        wait_done(n, ok);
        vecs++;
        if (n != W + 3 || !ok || {bif.found, bif.match_cnt, bif.first_pos} !== '0) begin
            errs++;
            $display("FAIL b2b_second: got n=%0d ok=%b found=%b cnt=%0d pos=%0d, want n=%0d ok=1 0 0 0",
                     n, ok, bif.found, bif.match_cnt, bif.first_pos, W + 3);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int n = 1;
        int dones = 0;
        bit ok = 1'b1;
        @(negedge clk);
        bif.start = 1'b1;
        bif.data_in = 16'h5555;
        @(posedge clk);
        #1 bif.start = 1'b0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (n == 5) begin
                bif.start = 1'b1;
                bif.data_in = 16'hFFFF;
            end
            if (n == 6) bif.start = 1'b0;
            if (bif.done) break;
            if (!bif.busy) ok = 1'b0;
            @(posedge clk);
            n++;
        end
        dones = bif.done ? 1 : 0;
        vecs++;
        if (n != W + 3 || !ok || {bif.found, bif.match_cnt, bif.first_pos} !== {1'b1, CW'(7), CW'(3)}) begin
            errs++;
            $display("FAIL ignore_result: got n=%0d ok=%b found=%b cnt=%0d pos=%0d, want n=%0d ok=1 1 7 3",
                     n, ok, bif.found, bif.match_cnt, bif.first_pos, W + 3);
        end
        repeat (W + 5) begin
            @(negedge clk);
            if (bif.done) dones++;
        end
        vecs++;
        if (dones != 1) begin
            errs++;
            $display("FAIL ignore_done_count: got %0d done pulses, want 1", dones);
        end
    endtask

    task automatic test_abort();
        int bad = 0;
        int n;
        bit ok;
        @(negedge clk);
        bif.start = 1'b1;
        bif.data_in = 16'h5555;
        @(posedge clk);
        #1 bif.start = 1'b0;
        repeat (7) @(negedge clk);
        clr_n = 1'b0;
        #1;
        vecs++;
        if ({bif.busy, bif.done, bif.found, bif.match_cnt, bif.first_pos} !== '0) begin
            errs++;
            $display("FAIL abort_outputs: got busy=%b done=%b found=%b cnt=%0d pos=%0d, want all 0",
                     bif.busy, bif.done, bif.found, bif.match_cnt, bif.first_pos);
        end
        @(negedge clk);
        clr_n = 1'b1;
        repeat (W + 6) begin
            @(negedge clk);
            if (bif.done || bif.busy) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL abort_quiet: got %0d cycles with busy/done after abort, want 0", bad);
        end
        bif.start = 1'b1;
        bif.data_in = 16'h0005;
        @(posedge clk);
        #1 bif.start = 1'b0;
        wait_done(n, ok);
        vecs++;
        if (n != W + 3 || !ok || {bif.found, bif.match_cnt, bif.first_pos} !== {1'b1, CW'(1), CW'(15)}) begin
            errs++;
            $display("FAIL abort_rescan: got n=%0d ok=%b found=%b cnt=%0d pos=%0d, want n=%0d ok=1 1 1 15",
                     n, ok, bif.found, bif.match_cnt, bif.first_pos, W + 3);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_scan_words();
        test_back_to_back();
        test_start_ignored();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
